// File: rtl/framer_pkg.sv
// Shared state encoding and default framing bytes for the packet framer.
package framer_pkg;

  typedef enum logic [2:0] {
    ST_WAKEUP,
    ST_IDLE,
    ST_HEADER,
    ST_SEQ,
    ST_FORWARD,
    ST_CHECKSUM,
    ST_FOOTER0,
    ST_FOOTER1
  } framer_state_e;

  localparam logic [7:0] HEAD_BYTE  = 8'h55;
  localparam logic [7:0] TAIL_BYTE0 = 8'hA5;
  localparam logic [7:0] TAIL_BYTE1 = 8'h5A;
  localparam logic [7:0] WAKEUP_CMD = 8'h99;

endpackage

// File: rtl/packet_framer_packer.sv
// Packs PackedNum narrow elements into one word (element 0 in the LSBs);
// flush_i closes a partial word early, leaving the unused upper slots zero.
module packet_framer_packer #(
  parameter  int UnpackedWidth = 2,
  parameter  int PackedNum     = 4,
  localparam int PackedWidth   = UnpackedWidth * PackedNum,
  localparam int IdxWidth      = (PackedNum > 1) ? $clog2(PackedNum) : 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     valid_i,
  output logic                     ready_o,
  input  logic [UnpackedWidth-1:0] data_i,
  input  logic                     flush_i,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic [PackedWidth-1:0]   data_o
);

  logic [PackedWidth-1:0] acc_q;
  logic [PackedWidth-1:0] word_next;
  logic [PackedWidth-1:0] out_q;
  logic [IdxWidth-1:0]    idx_q;
  logic                   out_valid_q;
  logic                   accept;
  logic                   last;

  // A held word can be replaced in the same cycle it is taken downstream.
  assign ready_o = !out_valid_q || ready_i;
  assign accept  = valid_i && ready_o;
  assign last    = flush_i || (idx_q == IdxWidth'(PackedNum - 1));
  assign valid_o = out_valid_q;
  assign data_o  = out_q;

  // NOTE: every variable assigned in always_comb gets a full default first, so no latch is inferred.
  always_comb begin
    word_next = acc_q;
    word_next[int'(idx_q) * UnpackedWidth +: UnpackedWidth] = data_i;
  end

  // NOTE: sequential state uses non-blocking assignments only; later assignments in the block win.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      // NOTE: the accumulator is a handful of flops, not a RAM, so it is cleared to keep zero padding valid after reset.
      acc_q       <= '0;
      out_q       <= '0;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      if (out_valid_q && ready_i) out_valid_q <= 1'b0;
      if (accept) begin
        if (last) begin
          out_q       <= word_next;
          out_valid_q <= 1'b1;
          acc_q       <= '0;
          idx_q       <= '0;
        end else begin
          acc_q <= word_next;
          idx_q <= idx_q + IdxWidth'(1);
        end
      end
    end
  end

endmodule

// File: rtl/packet_framer.sv
// Frames packed pixel words as: header, sequence, payload, optional XOR checksum,
// two tail bytes. A wakeup byte is sent once after every reset.
module packet_framer
  import framer_pkg::*;
#(
  parameter  int         UnpackedWidth  = 2,
  parameter  int         PackedNum      = 4,
  parameter  int         MaxPacketElems = 4096,
  parameter  bit         ChecksumEn     = 1'b1,
  parameter  logic [7:0] HeadByte       = HEAD_BYTE,
  parameter  logic [7:0] TailByte0      = TAIL_BYTE0,
  parameter  logic [7:0] TailByte1      = TAIL_BYTE1,
  parameter  logic [7:0] WakeupCmd      = WAKEUP_CMD,
  localparam int         PackedWidth    = UnpackedWidth * PackedNum,
  localparam int         LenWidth       = $clog2(MaxPacketElems + 1)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [LenWidth-1:0]      len_i,
  input  logic                     valid_i,
  output logic                     ready_o,
  input  logic [UnpackedWidth-1:0] unpacked_i,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic [PackedWidth-1:0]   data_o,
  output logic                     busy_o,
  output logic [7:0]               seq_o
);

  framer_state_e          state_q;
  logic [LenWidth-1:0]    len_q;
  logic [LenWidth-1:0]    elem_cnt_q;
  logic [LenWidth-1:0]    fire_cnt_q;
  logic [PackedWidth-1:0] csum_q;
  logic [PackedWidth-1:0] data_q;
  logic                   valid_q;
  logic [7:0]             seq_q;

  logic [LenWidth-1:0]    len_clamped;
  logic [LenWidth:0]      len_round;
  logic [LenWidth-1:0]    n_words;
  logic                   out_fire;
  logic                   can_load;
  logic                   accept;
  logic                   flush;
  logic                   in_forward;
  logic                   pk_in_ready;
  logic                   pk_valid;
  logic                   pk_ready;
  logic [PackedWidth-1:0] pk_data;

  always_comb begin
    len_clamped = len_i;
    if (len_i == '0)                                len_clamped = LenWidth'(1);
    else if (len_i > LenWidth'(MaxPacketElems))     len_clamped = LenWidth'(MaxPacketElems);
  end

  assign len_round  = {1'b0, len_q} + (LenWidth + 1)'(PackedNum - 1);
  assign n_words    = LenWidth'(len_round / (LenWidth + 1)'(PackedNum));

  assign in_forward = (state_q == ST_FORWARD);
  assign out_fire   = valid_q && ready_i;
  assign can_load   = !valid_q || ready_i;
  assign pk_ready   = in_forward && can_load;
  assign ready_o    = in_forward && pk_in_ready && (elem_cnt_q < len_q);
  assign accept     = valid_i && ready_o;
  assign flush      = (elem_cnt_q == len_q - LenWidth'(1));

  assign valid_o    = valid_q;
  assign data_o     = data_q;
  assign busy_o     = (state_q != ST_IDLE);
  assign seq_o      = seq_q;

  packet_framer_packer #(
    .UnpackedWidth (UnpackedWidth),
    .PackedNum     (PackedNum)
  ) u_packer (
    .clk_i   (clk_i),
    .rst_i   (!rst_ni),
    .valid_i (valid_i && ready_o),
    .ready_o (pk_in_ready),
    .data_i  (unpacked_i),
    .flush_i (flush),
    .valid_o (pk_valid),
    .ready_i (pk_ready),
    .data_o  (pk_data)
  );

  // Each state's word is loaded on the edge that enters the state, keeping data_o registered.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= ST_WAKEUP;
      len_q      <= '0;
      elem_cnt_q <= '0;
      fire_cnt_q <= '0;
      csum_q     <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      seq_q      <= '0;
    end else begin
      if (accept) elem_cnt_q <= elem_cnt_q + LenWidth'(1);
      case (state_q)
        ST_WAKEUP: begin
          if (out_fire) begin
            valid_q <= 1'b0;
            state_q <= ST_IDLE;
          end else if (!valid_q) begin
            valid_q <= 1'b1;
            data_q  <= PackedWidth'(WakeupCmd);
          end
        end
        ST_IDLE: begin
          if (valid_i) begin
            len_q   <= len_clamped;
            data_q  <= PackedWidth'(HeadByte);
            valid_q <= 1'b1;
            state_q <= ST_HEADER;
          end
        end
        ST_HEADER: begin
          if (out_fire) begin
            data_q  <= PackedWidth'(seq_q);
            csum_q  <= PackedWidth'(seq_q);
            state_q <= ST_SEQ;
          end
        end
        ST_SEQ: begin
          if (out_fire) begin
            valid_q <= 1'b0;
            state_q <= ST_FORWARD;
          end
        end
        ST_FORWARD: begin
          if (pk_valid && pk_ready) begin
            data_q  <= pk_data;
            valid_q <= 1'b1;
            csum_q  <= csum_q ^ pk_data;
          end else if (out_fire) begin
            valid_q <= 1'b0;
          end
          if (out_fire) begin
            fire_cnt_q <= fire_cnt_q + LenWidth'(1);
            if (fire_cnt_q == n_words - LenWidth'(1)) begin
              valid_q <= 1'b1;
              data_q  <= ChecksumEn ? csum_q : PackedWidth'(TailByte0);
              state_q <= ChecksumEn ? ST_CHECKSUM : ST_FOOTER0;
            end
          end
        end
        ST_CHECKSUM: begin
          if (out_fire) begin
            data_q  <= PackedWidth'(TailByte0);
            state_q <= ST_FOOTER0;
          end
        end
        ST_FOOTER0: begin
          if (out_fire) begin
            data_q  <= PackedWidth'(TailByte1);
            state_q <= ST_FOOTER1;
          end
        end
        ST_FOOTER1: begin
          if (out_fire) begin
            valid_q    <= 1'b0;
            state_q    <= ST_IDLE;
            seq_q      <= seq_q + 8'd1;
            elem_cnt_q <= '0;
            fire_cnt_q <= '0;
            csum_q     <= '0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_packet_framer.sv
// Randomised bench for packet_framer: a byte-stream model built from the framing
// rules is compared with every word that fires on the output.
module tb_packet_framer;

  logic        clk;
  logic        rst_a, rst_b;
  logic [12:0] len;
  logic        in_valid;
  logic [1:0]  in_data;
  logic        rdy;
  logic        sel;

  logic        v_a, r_a, busy_a, v_b, r_b, busy_b;
  logic [7:0]  d_a, seq_a, d_b, seq_b;
  logic        v_o, r_o, busy_o;
  logic [7:0]  d_o, seq_o;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  exp_seq;
  logic [1:0]  elems[$];

  packet_framer dut_a (
    .clk_i(clk), .rst_ni(rst_a), .len_i(len), .valid_i(in_valid), .ready_o(r_a),
    .unpacked_i(in_data), .valid_o(v_a), .ready_i(rdy), .data_o(d_a),
    .busy_o(busy_a), .seq_o(seq_a)
  );

  packet_framer #(.ChecksumEn(1'b0)) dut_b (
    .clk_i(clk), .rst_ni(rst_b), .len_i(len), .valid_i(in_valid), .ready_o(r_b),
    .unpacked_i(in_data), .valid_o(v_b), .ready_i(rdy), .data_o(d_b),
    .busy_o(busy_b), .seq_o(seq_b)
  );

  assign v_o    = sel ? v_b    : v_a;
  assign r_o    = sel ? r_b    : r_a;
  assign busy_o = sel ? busy_b : busy_a;
  assign d_o    = sel ? d_b    : d_a;
  assign seq_o  = sel ? seq_b  : seq_a;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic fill_random(input int n);
    elems.delete();
    for (int i = 0; i < n; i++) elems.push_back(2'($urandom_range(0, 3)));
  endtask

  // Drives the elements in `elems` as one packet and checks the emitted bytes.
  task automatic run_packet(input int len_in, input bit wake, input bit cs_en, input bit rand_rdy);
    int         eff, nw, ptr, first_bad;
    bit         done, pv, pr;
    logic [7:0] pd, word, cs;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];

    eff = (len_in == 0) ? 1 : (len_in > 4096) ? 4096 : len_in;
    nw  = (eff + 3) / 4;
    if (wake) exp_q.push_back(8'h99);
    exp_q.push_back(8'h55);
    exp_q.push_back(exp_seq);
    cs = exp_seq;
    for (int w = 0; w < nw; w++) begin
      word = 8'h00;
      for (int s = 0; s < 4; s++)
        if (w * 4 + s < eff) word = word | (8'(elems[w * 4 + s]) << (2 * s));
      exp_q.push_back(word);
      cs = cs ^ word;
    end
    if (cs_en) exp_q.push_back(cs);
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h5A);

    ptr = 0; done = 0; pv = 0; pr = 0; pd = 8'h00;
    len      = 13'(len_in);
    in_valid = 1'b1;
    in_data  = elems[0];
    rdy      = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    for (int cyc = 0; cyc < 20000 && !done; cyc++) begin
      @(negedge clk);
      if (pv && !pr) begin
        check("stall_valid", 32'(v_o), 32'd1);
        check("stall_data", 32'(d_o), 32'(pd));
      end
      if (v_o && rdy) got_q.push_back(d_o);
      if (in_valid && r_o) ptr++;
      pv = v_o; pr = rdy; pd = d_o;
      done = (got_q.size() >= exp_q.size());
      @(posedge clk);
      #1;
      // Length is only meaningful while Idle; scramble it everywhere else.
      len      = busy_o ? 13'($urandom) : 13'(len_in);
      in_valid = (ptr < eff);
      in_data  = (ptr < eff) ? elems[ptr] : 2'b00;
      rdy      = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    in_valid = 1'b0;
    rdy      = 1'b1;

    check("finished_in_budget", 32'(done), 32'd1);
    check("word_count", 32'(got_q.size()), 32'(exp_q.size()));
    first_bad = -1;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      if (got_q[i] !== exp_q[i] && first_bad < 0) first_bad = i;
    check("first_bad_word_idx", 32'(first_bad), 32'hFFFF_FFFF);
    check("elems_consumed", 32'(ptr), 32'(eff));
    check("busy_after", 32'(busy_o), 32'd0);
    exp_seq = exp_seq + 8'd1;
    check("seq_after", 32'(seq_o), 32'(exp_seq));
  endtask

  initial begin
    int ptr, n;
    sel = 1'b0; rst_a = 1'b0; rst_b = 1'b0;
    len = '0; in_valid = 1'b0; in_data = '0; rdy = 1'b1;
    exp_seq = 8'h00;

    @(posedge clk);
    #1;
    check("rst_valid", 32'(v_o), 32'd0);
    check("rst_data", 32'(d_o), 32'd0);
    check("rst_ready", 32'(r_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd1);
    check("rst_seq", 32'(seq_o), 32'd0);
    @(negedge clk);
    rst_a = 1'b1;

    // Packet 1 with wakeup, then packet 2 with a padded final word.
    elems = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd2, 2'd1, 2'd0};
    run_packet(8, 1'b1, 1'b1, 1'b0);
    elems = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd2};
    run_packet(5, 1'b0, 1'b1, 1'b0);

    // Same payload as packet 1 under random back-pressure.
    elems = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd2, 2'd1, 2'd0};
    run_packet(8, 1'b0, 1'b1, 1'b1);

    // Length clamping at both ends.
    elems = '{2'd3};
    run_packet(0, 1'b0, 1'b1, 1'b0);
    fill_random(4096);
    run_packet(5000, 1'b0, 1'b1, 1'b0);

    // A few random lengths with back-pressure.
    for (int p = 0; p < 4; p++) begin
      n = $urandom_range(1, 23);
      fill_random(n);
      run_packet(n, 1'b0, 1'b1, 1'b1);
    end

    // Reset in the middle of the payload.
    fill_random(8);
    ptr = 0; len = 13'd8; in_valid = 1'b1; in_data = elems[0]; rdy = 1'b1;
    for (int cyc = 0; cyc < 200 && ptr < 3; cyc++) begin
      @(negedge clk);
      if (in_valid && r_o) ptr++;
      @(posedge clk);
      #1;
      in_valid = (ptr < 8);
      in_data  = (ptr < 8) ? elems[ptr] : 2'b00;
    end
    check("abort_point_reached", 32'(ptr), 32'd3);
    @(negedge clk);
    rst_a = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("abort_valid", 32'(v_o), 32'd0);
    check("abort_ready", 32'(r_o), 32'd0);
    check("abort_seq", 32'(seq_o), 32'd0);
    @(negedge clk);
    rst_a = 1'b1;
    exp_seq = 8'h00;
    fill_random(6);
    run_packet(6, 1'b1, 1'b1, 1'b0);

    // Checksum-less instance: 256 packets to wrap the sequence counter.
    @(negedge clk);
    rst_a = 1'b0;
    sel   = 1'b1;
    rst_b = 1'b1;
    exp_seq = 8'h00;
    for (int p = 0; p < 256; p++) begin
      n = $urandom_range(1, 6);
      fill_random(n);
      run_packet(n, (p == 0), 1'b0, (p % 8 == 0));
    end
    check("seq_wrapped", 32'(seq_o), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
